// File: rtl/nn_sched_pkg.sv
// rtl/nn_sched_pkg.sv - shared types and helpers for the inference-core job scheduler
package nn_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      RESP   = 2'd3
   } sched_state_e;

   localparam int DEFAULT_TIMEOUT = 1023;

   // A single requester still needs a one-bit id field on the response side.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nn_job_scheduler_if.sv
// rtl/nn_job_scheduler_if.sv - requester-side job bus and result-side response bus
interface nn_job_scheduler_if
   import nn_sched_pkg::*;
#(
   parameter int BIT_WIDTH = 9,
   parameter int NUM_IN    = 2,
   parameter int NUM_OUT   = 1,
   parameter int NUM_REQ   = 2
);
   localparam int ID_W = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]                  req_valid;
   logic [NUM_REQ-1:0]                  req_ready;
   logic [NUM_REQ*NUM_IN*BIT_WIDTH-1:0] req_data;
   logic                                rsp_valid;
   logic                                rsp_ready;
   logic [ID_W-1:0]                     rsp_id;
   logic [NUM_OUT*BIT_WIDTH-1:0]        rsp_data;
   logic                                rsp_timeout;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_timeout
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_timeout
   );

endinterface

// File: rtl/nn_rr_arbiter.sv
// rtl/nn_rr_arbiter.sv - combinational round-robin pick of the first request at or after the pointer
module nn_rr_arbiter
   import nn_sched_pkg::*;
#(
   parameter int NUM_REQ = 2,
   localparam int ID_W   = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [ID_W-1:0]    idx_o,
   output logic               any_o
);

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin : scan
         automatic int k = (int'(ptr_i) + i) % NUM_REQ;
         if (!any_o && req_i[k]) begin
            any_o      = 1'b1;
            grant_o[k] = 1'b1;
            idx_o      = ID_W'(k);
         end
      end
   end

endmodule

// File: rtl/nn_job_scheduler.sv
// rtl/nn_job_scheduler.sv - shares one inference core between NUM_REQ requesters with a watchdog
module nn_job_scheduler
   import nn_sched_pkg::*;
#(
   parameter int BIT_WIDTH = 9,
   parameter int NUM_IN    = 2,
   parameter int NUM_OUT   = 1,
   parameter int NUM_REQ   = 2,
   parameter int TIMEOUT   = DEFAULT_TIMEOUT,
   parameter int CNT_W     = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   nn_job_scheduler_if.slave             job,
   output logic                          nn_start,
   output logic [NUM_IN*BIT_WIDTH-1:0]   nn_inputs,
   input  logic                          nn_done,
   input  logic [NUM_OUT*BIT_WIDTH-1:0]  nn_outputs,
   output logic                          busy,
   output logic [CNT_W-1:0]              timeout_count
);

   localparam int ID_W  = id_width(NUM_REQ);
   localparam int IN_W  = NUM_IN * BIT_WIDTH;
   localparam int OUT_W = NUM_OUT * BIT_WIDTH;
   localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   sched_state_e     state_q, state_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic [IN_W-1:0]  inputs_q, inputs_d;
   logic [OUT_W-1:0] data_q, data_d;
   logic             tmo_q, tmo_d;
   logic [CNT_W-1:0] tcnt_q, tcnt_d;

   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_idx;
   logic               gnt_any;
   logic               wd_expired;

   nn_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_i   (job.req_valid),
      .ptr_i   (ptr_q),
      .grant_o (gnt),
      .idx_o   (gnt_idx),
      .any_o   (gnt_any)
   );

   // The count reaches TIMEOUT-1 in the cycle where the current value is TIMEOUT-2.
   assign wd_expired = (wd_q == WD_W'(TIMEOUT - 2));

   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (gnt_any)                state_d = LAUNCH;
         LAUNCH:                              state_d = RUN;
         RUN:     if (nn_done || wd_expired)  state_d = RESP;
         RESP:    if (job.rsp_ready)          state_d = IDLE;
         default:                             state_d = IDLE;
      endcase
   end

   always_comb begin
      job.req_ready = '0;
      job.rsp_valid = 1'b0;
      nn_start      = 1'b0;
      busy          = (state_q != IDLE);
      case (state_q)
         IDLE:    if (!reset) job.req_ready = gnt;
         LAUNCH:  nn_start      = 1'b1;
         RESP:    job.rsp_valid = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      ptr_d    = ptr_q;
      id_d     = id_q;
      wd_d     = wd_q;
      inputs_d = inputs_q;
      data_d   = data_q;
      tmo_d    = tmo_q;
      tcnt_d   = tcnt_q;
      case (state_q)
         IDLE: if (gnt_any) begin
            inputs_d = job.req_data[int'(gnt_idx)*IN_W +: IN_W];
            id_d     = gnt_idx;
         end
         LAUNCH: wd_d = '0;
         RUN: begin
            wd_d = wd_q + WD_W'(1);
            if (nn_done) begin
               data_d = nn_outputs;
               tmo_d  = 1'b0;
            end else if (wd_expired) begin
               data_d = '0;
               tmo_d  = 1'b1;
               tcnt_d = (tcnt_q == '1) ? tcnt_q : tcnt_q + CNT_W'(1);
            end
         end
         RESP: if (job.rsp_ready) begin
            ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q    <= '0;
         id_q     <= '0;
         wd_q     <= '0;
         inputs_q <= '0;
         data_q   <= '0;
         tmo_q    <= 1'b0;
         tcnt_q   <= '0;
      end else begin
         ptr_q    <= ptr_d;
         id_q     <= id_d;
         wd_q     <= wd_d;
         inputs_q <= inputs_d;
         data_q   <= data_d;
         tmo_q    <= tmo_d;
         tcnt_q   <= tcnt_d;
      end
   end

   assign nn_inputs       = inputs_q;
   assign job.rsp_id      = id_q;
   assign job.rsp_data    = data_q;
   assign job.rsp_timeout = tmo_q;
   assign timeout_count   = tcnt_q;

endmodule

// File: tb/tb_nn_job_scheduler.sv
// tb/tb_nn_job_scheduler.sv - randomized job-level bench for nn_job_scheduler against a transaction model
module tb_nn_job_scheduler;

   localparam int BW = 9;
   localparam int NI = 2;
   localparam int NO = 1;
   localparam int NR = 2;
   localparam int TO = 8;
   localparam int CW = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic              nn_start;
   logic [NI*BW-1:0]  nn_inputs;
   logic              nn_done;
   logic [NO*BW-1:0]  nn_outputs;
   logic              busy;
   logic [CW-1:0]     timeout_count;

   nn_job_scheduler_if #(.BIT_WIDTH(BW), .NUM_IN(NI), .NUM_OUT(NO), .NUM_REQ(NR)) bus ();

   nn_job_scheduler #(
      .BIT_WIDTH(BW), .NUM_IN(NI), .NUM_OUT(NO), .NUM_REQ(NR), .TIMEOUT(TO), .CNT_W(CW)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .job           (bus),
      .nn_start      (nn_start),
      .nn_inputs     (nn_inputs),
      .nn_done       (nn_done),
      .nn_outputs    (nn_outputs),
      .busy          (busy),
      .timeout_count (timeout_count)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   int m_ptr = 0;
   int m_tcnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_idle();
      bus.req_valid  = '0;
      bus.req_data   = '0;
      bus.rsp_ready  = 1'b0;
      nn_done        = 1'b0;
      nn_outputs     = '0;
   endtask

   // Entered at posedge+1; returns at posedge+1 of the first cycle after reset is released.
   task automatic do_reset(input string tag);
      drive_idle();
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check({tag, "_busy"},      busy, 0);
      check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
      check({tag, "_req_ready"}, bus.req_ready, 0);
      check({tag, "_nn_start"},  nn_start, 0);
      check({tag, "_rsp_data"},  bus.rsp_data, 0);
      check({tag, "_rsp_id"},    bus.rsp_id, 0);
      check({tag, "_rsp_tmo"},   bus.rsp_timeout, 0);
      check({tag, "_nn_inputs"}, nn_inputs, 0);
      check({tag, "_tcount"},    timeout_count, 0);
      m_ptr  = 0;
      m_tcnt = 0;
      @(posedge clock); #1;
   endtask

   // One complete job, cycle 0 = the idle cycle in which the request is presented.
   task automatic run_job(input logic [1:0] mask, input logic [NI*BW-1:0] d0, input logic [NI*BW-1:0] d1,
                          input logic [BW-1:0] val, input int k, input int stall, input bit done_always);
      int g, idx, done_cyc, exp_resp, c, starts, start_cyc, leaks, first_rsp;
      bit exp_tmo, fin;
      logic [BW-1:0]    exp_data;
      logic [NR-1:0]    onehot, rest;
      logic [NI*BW-1:0] exp_in;
      g = -1;
      for (int i = 0; i < NR; i++) begin
         idx = (m_ptr + i) % NR;
         if (g < 0 && mask[idx]) g = idx;
      end
      onehot = '0;
      onehot[g] = 1'b1;
      rest = mask & ~onehot;
      exp_in   = (g == 1) ? d1 : d0;
      done_cyc = done_always ? 2 : 1 + k;
      exp_tmo  = !done_always && (k > TO - 1);
      exp_resp = exp_tmo ? TO + 1 : done_cyc + 1;
      exp_data = exp_tmo ? '0 : val;
      if (exp_tmo && m_tcnt < 65535) m_tcnt++;
      c = 0; starts = 0; start_cyc = -1; leaks = 0; first_rsp = -1; fin = 0;
      while (!fin && c < 60) begin
         bus.req_valid = (c == 0) ? mask : rest;
         bus.req_data  = {d1, d0};
         nn_done       = done_always || (c == done_cyc);
         nn_outputs    = (c <= done_cyc) ? val : ~val;
         bus.rsp_ready = (c >= exp_resp + stall);
         @(negedge clock);
         if (c == 0) begin
            check("req_ready", bus.req_ready, onehot);
            check("busy_idle", busy, 0);
         end else if (bus.req_ready != '0) begin
            leaks++;
         end
         if (nn_start) begin
            starts++;
            if (start_cyc < 0) start_cyc = c;
         end
         if (c == 1) begin
            check("nn_inputs", nn_inputs, exp_in);
            check("busy_run", busy, 1);
         end
         if (bus.rsp_valid) begin
            if (first_rsp < 0) begin
               first_rsp = c;
               check("rsp_cycle", c, exp_resp);
               check("tcount", timeout_count, m_tcnt);
            end
            check("rsp_id", bus.rsp_id, g);
            check("rsp_data", bus.rsp_data, exp_data);
            check("rsp_timeout", bus.rsp_timeout, exp_tmo);
            if (bus.rsp_ready) fin = 1;
         end
         @(posedge clock); #1;
         c++;
      end
      check("handshake", fin, 1);
      check("start_count", starts, 1);
      check("start_cycle", start_cyc, 1);
      check("ready_leak", leaks, 0);
      if (fin) begin
         check("rsp_hold", c - 1, exp_resp + stall);
         m_ptr = (g + 1) % NR;
      end else begin
         do_reset("recover");
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      drive_idle();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      do_reset("por");

      // deterministic single job
      run_job(2'b01, {9'h010, 9'h020}, 18'h0, 9'h03A, 5, 0, 0);

      // contention from a fresh pointer
      do_reset("pre_rr");
      for (int j = 0; j < 4; j++)
         run_job(2'b11, 18'($urandom), 18'($urandom), 9'($urandom), $urandom_range(1, 6), 0, 0);

      // watchdog, then a normal job
      run_job(2'b11, 18'($urandom), 18'($urandom), 9'($urandom), 100, 0, 0);
      run_job(2'b10, 18'($urandom), 18'($urandom), 9'($urandom), 3, 0, 0);

      // backpressure
      run_job(2'b11, 18'($urandom), 18'($urandom), 9'($urandom), 2, 10, 0);

      // done held from launch; done exactly at the last watchdog count; done one cycle too late
      run_job(2'b11, 18'($urandom), 18'($urandom), 9'($urandom), 1, 0, 1);
      run_job(2'b11, 18'($urandom), 18'($urandom), 9'($urandom), TO - 1, 0, 0);
      run_job(2'b11, 18'($urandom), 18'($urandom), 9'($urandom), TO, 0, 0);

      // reset three cycles after nn_start, pointer left at 1 beforehand
      run_job(2'b01, 18'($urandom), 18'($urandom), 9'($urandom), 2, 0, 0);
      bus.req_valid = 2'b11;
      bus.req_data  = {18'($urandom), 18'($urandom)};
      nn_done       = 1'b0;
      @(posedge clock); #1;
      repeat (3) @(posedge clock);
      #1;
      do_reset("mid_run");
      run_job(2'b11, 18'($urandom), 18'($urandom), 9'($urandom), 4, 0, 0);

      for (int j = 0; j < 30; j++)
         run_job(2'($urandom_range(1, 3)), 18'($urandom), 18'($urandom), 9'($urandom),
                 $urandom_range(1, 9), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
